route_scheduler: RTL and testbench
==================================

// Module: route_scheduler
// PURPOSE
//  Sequences memory_top through a run of routing windows for a layer: issues startAddr/finalAddr/routeEn
//  per window, waits for finished, captures dataOut, hands it downstream on a valid/ready port.
//  Sits between the layer controller (start/config) and memory_top + PE-array input stage.
// PARAMETERS
//  MaxWidth     9     max words per routed window (memory_top dataOut lanes)
//  DataWidth    8     bits per word
//  Depth        128   buffer depth; AddrWidth = $clog2(Depth)
//  CountWidth   8     width of window count/index
//  TimeoutCyc   1024  max cycles waiting on finished before error
// PORTS
//  clk          in   1                   clock
//  rst          in   1                   synchronous reset, active-low
//  start        in   1                   begin run (sampled in IDLE/DONE/ERR only)
//  abort        in   1                   cancel run; to IDLE
//  baseAddr     in   AddrWidth           start address of window 0
//  windowLen    in   $clog2(MaxWidth+1)  words per window, 1..MaxWidth
//  stride       in   AddrWidth           address step between windows
//  numWindows   in   CountWidth          windows in run
//  routeEn      out  1                   to memory_top
//  startAddr    out  AddrWidth           to memory_top, window start
//  finalAddr    out  AddrWidth           to memory_top, exclusive end = startAddr+windowLen
//  finished     in   1                   from memory_top, window routed
//  routeData    in   MaxWidth*DataWidth  from memory_top dataOut
//  outValid     out  1 / outReady in 1   downstream handshake
//  outData      out  MaxWidth*DataWidth  captured window; outIdx out CountWidth = window number
//  busy, done, err  out 1 each           run active / 1-cycle completion pulse / sticky error
// BEHAVIOUR
//  - Reset (rst==0 at edge): state IDLE; all outputs 0; internal counters 0.
//  - States: IDLE, ROUTE, HOLD, DONE, ERR. All outputs registered.
//  - IDLE/DONE/ERR + start: validate config that cycle (width CountWidth+AddrWidth+1 arithmetic):
//    numWindows==0 -> DONE, done=1 next cycle, no routeEn; windowLen==0 or >MaxWidth, or
//    baseAddr+(numWindows-1)*stride+windowLen > Depth-1 -> ERR, err=1; else -> ROUTE with
//    startAddr=baseAddr, finalAddr=baseAddr+windowLen, outIdx=0, routeEn=1, busy=1, err cleared.
//  - ROUTE: routeEn held 1; watchdog counts. finished==1 sampled -> outData<=routeData, outValid=1,
//    routeEn=0, watchdog cleared, -> HOLD. Watchdog reaching TimeoutCyc -> ERR, routeEn=0, busy=0.
//  - HOLD: outValid/outData/outIdx stable until outValid&&outReady. On transfer: last window
//    (outIdx==numWindows_reg-1) -> DONE, outValid=0, busy=0, done=1 one cycle; else outValid=0,
//    startAddr+=stride, finalAddr+=stride, outIdx+=1, routeEn=1, -> ROUTE. Guarantees >=1 cycle
//    routeEn low between windows (memory_top re-arm). Min per-window latency: finished->outValid 1 cycle.
//  - finished ignored outside ROUTE. Config regs latched at accepted start; inputs may change after.
//  - DONE: done pulses once then holds 0; state stays DONE until start. ERR: err sticky until accepted start.
//  - abort in any state: next cycle IDLE, routeEn=0, outValid=0, busy=0, err unchanged, no done.
//    abort and start same cycle: abort wins. Reset mid-run: same as reset, no done/err.
// STRUCTURE
//  - route_sched_pkg.vh: state encodings, ST_IDLE..ST_ERR localparams; shared AddrWidth derivation.
//  - Sub-module route_watchdog: loadable down-counter, clear/enable inputs, expired output.
//  - Address/index regs, capture register and FSM live in route_scheduler.
// TESTING (bench instantiates memory_top behind scheduler; Depth=128, MaxWidth=9, DataWidth=8)
//  - base=0,len=9,stride=9,num=3, outReady=1 -> 3 windows: start/final 0/9, 9/18, 18/27; outIdx 0,1,2; one done.
//  - same with outReady low 5 cycles per window -> outData stable while stalled; routeEn 0 throughout HOLD.
//  - num=0 -> done=1 cycle after start, routeEn never 1; len=10 -> err=1, routeEn never 1.
//  - base=120,len=9,num=1 (end 129>127) -> err=1; base=100,len=9,stride=5,num=4 (end 124) -> ok.
//  - finished tied 0 -> err=1 exactly TimeoutCyc cycles after routeEn rose, routeEn back to 0.
//  - abort during window 2 of 3 -> IDLE next cycle, no done; restart with start -> full clean run.

Source files
------------

// File: rtl/route_scheduler_pkg.sv
// Shared sizing, state encoding and config-range arithmetic for the route scheduler.
// The window-end helper is evaluated at full width so an oversized run cannot wrap into range.
package route_scheduler_pkg;

  localparam int MaxWidth   = 9;
  localparam int DataWidth  = 8;
  localparam int Depth      = 128;
  localparam int CountWidth = 8;
  localparam int TimeoutCyc = 1024;

  localparam int AddrWidth  = $clog2(Depth);
  localparam int LenWidth   = $clog2(MaxWidth + 1);
  localparam int DataBits   = MaxWidth * DataWidth;
  localparam int CheckWidth = CountWidth + AddrWidth + 1;
  localparam int TimerWidth = $clog2(TimeoutCyc + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ROUTE,
    ST_HOLD,
    ST_DONE,
    ST_ERR
  } state_e;

  // Exclusive end address of the last window; caller guarantees count >= 1.
  function automatic logic [CheckWidth-1:0] windowEnd(
    input logic [AddrWidth-1:0]  base,
    input logic [CountWidth-1:0] count,
    input logic [AddrWidth-1:0]  stride,
    input logic [LenWidth-1:0]   len
  );
    logic [CheckWidth-1:0] b, n, s, l;
    b = CheckWidth'(base);
    n = CheckWidth'(count);
    s = CheckWidth'(stride);
    l = CheckWidth'(len);
    return b + (n - CheckWidth'(1)) * s + l;
  endfunction

endpackage

// File: rtl/route_scheduler_watchdog.sv
// Down-counting watchdog: clear reloads the full budget, enable burns one cycle of it,
// and expired reports an exhausted budget.
module route_watchdog
  import route_scheduler_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  logic [TimerWidth-1:0] cnt_q, cnt_d;

  // Loaded with TimeoutCyc-1 so the owner sees expiry on exactly the TimeoutCyc-th enabled edge.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = TimerWidth'(TimeoutCyc - 1);
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - TimerWidth'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/route_scheduler.sv
// Steps memory_top through a layer's routing windows and hands each captured window
// downstream on a valid/ready port; all outputs come straight from registers.
module route_scheduler
  import route_scheduler_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [AddrWidth-1:0]  baseAddr_i,
  input  logic [LenWidth-1:0]   windowLen_i,
  input  logic [AddrWidth-1:0]  stride_i,
  input  logic [CountWidth-1:0] numWindows_i,
  output logic                  routeEn_o,
  output logic [AddrWidth-1:0]  startAddr_o,
  output logic [AddrWidth-1:0]  finalAddr_o,
  input  logic                  finished_i,
  input  logic [DataBits-1:0]   routeData_i,
  output logic                  outValid_o,
  input  logic                  outReady_i,
  output logic [DataBits-1:0]   outData_o,
  output logic [CountWidth-1:0] outIdx_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  state_e                state_q;
  logic [AddrWidth-1:0]  stride_q;
  logic [CountWidth-1:0] numWin_q;
  logic                  routeEn_q, outValid_q, busy_q, done_q, err_q;
  logic [AddrWidth-1:0]  startAddr_q, finalAddr_q;
  logic [DataBits-1:0]   outData_q;
  logic [CountWidth-1:0] outIdx_q;

  logic cfgBad, lastWindow, wdExpired;

  assign cfgBad = (windowLen_i == '0) ||
                  (windowLen_i > LenWidth'(MaxWidth)) ||
                  (windowEnd(baseAddr_i, numWindows_i, stride_i, windowLen_i) >
                   CheckWidth'(Depth - 1));

  assign lastWindow = (outIdx_q == numWin_q - CountWidth'(1));

  // The watchdog sits reloaded whenever no window is in flight, so each window gets a full budget.
  route_watchdog uWatchdog (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clear_i   (state_q != ST_ROUTE),
    .en_i      (state_q == ST_ROUTE),
    .expired_o (wdExpired)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      stride_q    <= '0;
      numWin_q    <= '0;
      routeEn_q   <= 1'b0;
      startAddr_q <= '0;
      finalAddr_q <= '0;
      outValid_q  <= 1'b0;
      outData_q   <= '0;
      outIdx_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort_i) begin
        state_q    <= ST_IDLE;
        routeEn_q  <= 1'b0;
        outValid_q <= 1'b0;
        busy_q     <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE, ST_DONE, ST_ERR: begin
            if (start_i) begin
              err_q    <= 1'b0;
              stride_q <= stride_i;
              numWin_q <= numWindows_i;
              if (numWindows_i == '0) begin
                state_q <= ST_DONE;
                done_q  <= 1'b1;
              end else if (cfgBad) begin
                state_q <= ST_ERR;
                err_q   <= 1'b1;
              end else begin
                state_q     <= ST_ROUTE;
                startAddr_q <= baseAddr_i;
                finalAddr_q <= baseAddr_i + AddrWidth'(windowLen_i);
                outIdx_q    <= '0;
                routeEn_q   <= 1'b1;
                busy_q      <= 1'b1;
              end
            end
          end
          ST_ROUTE: begin
            // A finish on the same edge as expiry still counts as a routed window.
            if (finished_i) begin
              outData_q  <= routeData_i;
              outValid_q <= 1'b1;
              routeEn_q  <= 1'b0;
              state_q    <= ST_HOLD;
            end else if (wdExpired) begin
              state_q   <= ST_ERR;
              err_q     <= 1'b1;
              routeEn_q <= 1'b0;
              busy_q    <= 1'b0;
            end
          end
          ST_HOLD: begin
            if (outReady_i) begin
              outValid_q <= 1'b0;
              if (lastWindow) begin
                state_q <= ST_DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                startAddr_q <= startAddr_q + stride_q;
                finalAddr_q <= finalAddr_q + stride_q;
                outIdx_q    <= outIdx_q + CountWidth'(1);
                routeEn_q   <= 1'b1;
                state_q     <= ST_ROUTE;
              end
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign routeEn_o   = routeEn_q;
  assign startAddr_o = startAddr_q;
  assign finalAddr_o = finalAddr_q;
  assign outValid_o  = outValid_q;
  assign outData_o   = outData_q;
  assign outIdx_o    = outIdx_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_route_scheduler.sv
// Bench for route_scheduler: a behavioural memory_top answers each routed window after a
// random latency, and every run is checked against windows derived from the run rules.
module tb_route_scheduler;
  import route_scheduler_pkg::*;

  logic                  clk = 1'b0;
  logic                  rstN = 1'b0;
  logic                  start = 1'b0;
  logic                  abort = 1'b0;
  logic [AddrWidth-1:0]  baseAddr = '0;
  logic [LenWidth-1:0]   windowLen = '0;
  logic [AddrWidth-1:0]  stride = '0;
  logic [CountWidth-1:0] numWindows = '0;
  logic                  routeEn;
  logic [AddrWidth-1:0]  startAddr, finalAddr;
  logic                  finished = 1'b0;
  logic [DataBits-1:0]   routeData = '0;
  logic                  outValid;
  logic                  outReady = 1'b0;
  logic [DataBits-1:0]   outData;
  logic [CountWidth-1:0] outIdx;
  logic                  busy, done, err;

  int  testsRun = 0;
  int  testsFailed = 0;
  logic [7:0] mem [128];
  bit  tieFinishedLow = 1'b0;
  int  hiCnt = 0;
  int  lat = 1;
  int  routeEnHighCycles = 0;

  always #5 clk = ~clk;

  route_scheduler dut (
    .clk_i        (clk),
    .rst_ni       (rstN),
    .start_i      (start),
    .abort_i      (abort),
    .baseAddr_i   (baseAddr),
    .windowLen_i  (windowLen),
    .stride_i     (stride),
    .numWindows_i (numWindows),
    .routeEn_o    (routeEn),
    .startAddr_o  (startAddr),
    .finalAddr_o  (finalAddr),
    .finished_i   (finished),
    .routeData_i  (routeData),
    .outValid_o   (outValid),
    .outReady_i   (outReady),
    .outData_o    (outData),
    .outIdx_o     (outIdx),
    .busy_o       (busy),
    .done_o       (done),
    .err_o        (err)
  );

  function automatic logic [71:0] memWindow(input int s, input int n);
    logic [71:0] d;
    d = '0;
    for (int i = 0; i < n && i < 9; i++) d[i*8 +: 8] = mem[7'(s + i)];
    return d;
  endfunction

  // memory_top stand-in: one finished pulse per routeEn episode, garbage on the data lanes otherwise.
  always @(negedge clk) begin
    if (routeEn) routeEnHighCycles++;
    routeData = {8'($urandom), 32'($urandom), 32'($urandom)};
    if (!routeEn || tieFinishedLow) begin
      finished = 1'b0;
      hiCnt = 0;
    end else begin
      if (hiCnt == 0) lat = $urandom_range(1, 4);
      hiCnt++;
      if (hiCnt == lat) begin
        finished = 1'b1;
        routeData = memWindow(int'(startAddr), int'(finalAddr) - int'(startAddr));
      end else begin
        finished = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: observed hang expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse start with the given config, then scramble the config inputs since they must be latched.
  task automatic applyStimulus(input int base, input int len, input int str, input int num);
    baseAddr   = 7'(base);
    windowLen  = 4'(len);
    stride     = 7'(str);
    numWindows = 8'(num);
    start = 1'b1;
    tick();
    start = 1'b0;
    baseAddr   = 7'($urandom);
    windowLen  = 4'($urandom);
    stride     = 7'($urandom);
    numWindows = 8'($urandom);
  endtask

  task automatic runWindowTest(input int base, input int len, input int str, input int num,
                               input int stallMin, input int stallMax);
    int endAddr, waitCnt, stall, wStart;
    logic [71:0] expData;
    endAddr = base + (num - 1) * str + len;
    routeEnHighCycles = 0;
    outReady = (stallMax == 0);
    applyStimulus(base, len, str, num);
    if (num == 0) begin
      checkOutput("num0_done", 72'(done), 72'(1));
      checkOutput("num0_busy", 72'(busy), 72'(0));
      checkOutput("num0_err", 72'(err), 72'(0));
      tick();
      checkOutput("num0_done_once", 72'(done), 72'(0));
      tick();
      checkOutput("num0_no_route", 72'(routeEnHighCycles), 72'(0));
    end else if (len < 1 || len > 9 || endAddr > 127) begin
      checkOutput("cfg_err", 72'(err), 72'(1));
      checkOutput("cfg_err_busy", 72'(busy), 72'(0));
      checkOutput("cfg_err_done", 72'(done), 72'(0));
      tick();
      tick();
      checkOutput("cfg_err_sticky", 72'(err), 72'(1));
      checkOutput("cfg_err_no_route", 72'(routeEnHighCycles), 72'(0));
    end else begin
      checkOutput("run_routeEn", 72'(routeEn), 72'(1));
      checkOutput("run_busy", 72'(busy), 72'(1));
      checkOutput("run_err_clear", 72'(err), 72'(0));
      for (int w = 0; w < num; w++) begin
        wStart = base + w * str;
        waitCnt = 0;
        while (!outValid && waitCnt < 50) begin
          tick();
          waitCnt++;
        end
        checkOutput("win_valid", 72'(outValid), 72'(1));
        if (!outValid) return;
        expData = memWindow(wStart, len);
        checkOutput("win_idx", 72'(outIdx), 72'(w));
        checkOutput("win_start", 72'(startAddr), 72'(wStart));
        checkOutput("win_final", 72'(finalAddr), 72'(wStart + len));
        checkOutput("win_data", outData, expData);
        checkOutput("win_routeEn_low", 72'(routeEn), 72'(0));
        stall = $urandom_range(stallMin, stallMax);
        if (stall > 0) outReady = 1'b0;
        for (int s = 0; s < stall; s++) begin
          tick();
          checkOutput("stall_data", outData, expData);
          checkOutput("stall_valid", 72'(outValid), 72'(1));
          checkOutput("stall_routeEn", 72'(routeEn), 72'(0));
          checkOutput("stall_idx", 72'(outIdx), 72'(w));
        end
        outReady = 1'b1;
        tick();
        outReady = (stallMax == 0);
        checkOutput("xfer_valid_low", 72'(outValid), 72'(0));
        if (w == num - 1) begin
          checkOutput("last_done", 72'(done), 72'(1));
          checkOutput("last_busy", 72'(busy), 72'(0));
          checkOutput("last_routeEn", 72'(routeEn), 72'(0));
          tick();
          checkOutput("last_done_once", 72'(done), 72'(0));
        end else begin
          checkOutput("next_routeEn", 72'(routeEn), 72'(1));
          checkOutput("next_idx", 72'(outIdx), 72'(w + 1));
          checkOutput("next_done", 72'(done), 72'(0));
        end
      end
    end
    outReady = 1'b0;
  endtask

  initial begin
    int n, waitCnt, doneSeen, num, len, str, span, base;
    for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);

    // Reset state.
    rstN = 1'b0;
    tick();
    tick();
    checkOutput("rst_routeEn", 72'(routeEn), 72'(0));
    checkOutput("rst_busy", 72'(busy), 72'(0));
    checkOutput("rst_done", 72'(done), 72'(0));
    checkOutput("rst_err", 72'(err), 72'(0));
    checkOutput("rst_outValid", 72'(outValid), 72'(0));
    checkOutput("rst_addr", 72'({startAddr, finalAddr}), 72'(0));
    checkOutput("rst_outIdx", 72'(outIdx), 72'(0));
    checkOutput("rst_outData", outData, 72'(0));
    rstN = 1'b1;
    tick();

    // Directed runs.
    runWindowTest(0, 9, 9, 3, 0, 0);
    runWindowTest(0, 9, 9, 3, 5, 5);
    runWindowTest(5, 3, 2, 0, 0, 0);
    runWindowTest(0, 10, 1, 2, 0, 0);
    runWindowTest(0, 0, 1, 2, 0, 0);
    runWindowTest(120, 9, 0, 1, 0, 0);
    runWindowTest(100, 9, 5, 4, 0, 1);
    runWindowTest(118, 9, 0, 1, 0, 0);
    runWindowTest(119, 9, 0, 1, 0, 0);

    // Watchdog: memory_top never answers.
    tieFinishedLow = 1'b1;
    applyStimulus(10, 4, 3, 2);
    checkOutput("to_routeEn_rise", 72'(routeEn), 72'(1));
    n = 0;
    while (!err && n < TimeoutCyc + 10) begin
      tick();
      n++;
    end
    checkOutput("to_cycles", 72'(n), 72'(1024));
    checkOutput("to_routeEn", 72'(routeEn), 72'(0));
    checkOutput("to_busy", 72'(busy), 72'(0));
    tieFinishedLow = 1'b0;

    // Abort during window 2 of 3, then a clean rerun.
    outReady = 1'b1;
    applyStimulus(0, 9, 9, 3);
    waitCnt = 0;
    while (!(outIdx == 8'd1 && routeEn) && waitCnt < 100) begin
      tick();
      waitCnt++;
    end
    checkOutput("abort_reach_win2", 72'(outIdx == 8'd1 && routeEn), 72'(1));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    outReady = 1'b0;
    checkOutput("abort_busy", 72'(busy), 72'(0));
    checkOutput("abort_routeEn", 72'(routeEn), 72'(0));
    checkOutput("abort_outValid", 72'(outValid), 72'(0));
    checkOutput("abort_err", 72'(err), 72'(0));
    doneSeen = int'(done);
    for (int i = 0; i < 4; i++) begin
      tick();
      doneSeen += int'(done) + int'(routeEn);
    end
    checkOutput("abort_quiet", 72'(doneSeen), 72'(0));
    runWindowTest(0, 9, 9, 3, 0, 2);

    // Reset mid-run produces neither done nor err.
    applyStimulus(0, 4, 4, 3);
    tick();
    rstN = 1'b0;
    tick();
    rstN = 1'b1;
    checkOutput("midrst_busy", 72'(busy), 72'(0));
    checkOutput("midrst_flags", 72'({done, err, routeEn}), 72'(0));
    tick();

    // Random legal runs with random stalls.
    for (int r = 0; r < 8; r++) begin
      num  = $urandom_range(1, 4);
      len  = $urandom_range(1, 9);
      str  = $urandom_range(0, 20);
      span = (num - 1) * str + len;
      base = $urandom_range(0, 127 - span);
      runWindowTest(base, len, str, num, 0, 3);
    end
    // Random configs of any legality.
    for (int r = 0; r < 6; r++) begin
      runWindowTest($urandom_range(0, 127), $urandom_range(0, 10), $urandom_range(0, 40),
                    $urandom_range(0, 3), 0, 2);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
